// File: rtl/xm_mem_port.sv
// xm_mem_port: X/M-stage memory port controller for the dual-issue pipeline.
// Arbitrates the top and bottom slots onto a single-port data memory,
// serializing top-then-bottom (one stall cycle) when both slots access memory,
// and returns load data per slot with a one-cycle valid pulse.
// Optional feature: define XM_STORE_FWD_EN to forward a top store's data to a
// same-address bottom load instead of serializing the pair.
module xm_mem_port #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_top,
  input  logic              mem_bot,
  input  logic              we_top,
  input  logic              we_bot,
  input  logic [ADDR_W-1:0] addr_top,
  input  logic [ADDR_W-1:0] addr_bot,
  input  logic [DATA_W-1:0] data_top,
  input  logic [DATA_W-1:0] data_bot,
  input  logic [DATA_W-1:0] dmem_q,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_top,
  output logic [DATA_W-1:0] rdata_bot,
  output logic              rvalid_top,
  output logic              rvalid_bot
);

  typedef enum logic {
    IDLE = 1'b0,
    BOT  = 1'b1
  } state_t;

  // One entry of the result-tracking pipeline. slot: 0 = top, 1 = bottom.
  // fwd marks a bottom load satisfied from forwarded store data, not dmem_q.
  typedef struct packed {
    logic issued;
    logic slot;
    logic is_load;
    logic fwd;
  } tag_t;

  localparam tag_t TAG_NONE = '{issued: 1'b0, slot: 1'b0, is_load: 1'b0, fwd: 1'b0};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] bot_addr_q;
  logic [DATA_W-1:0] bot_data_q;
  logic              bot_we_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic              fwd_hit;
  tag_t              issue_tag;
  tag_t              tag_q0;   // access issued last cycle; dmem_q valid now
  tag_t              tag_q1;   // result captured last cycle; drives rvalid_*

  // Top store followed by a same-address bottom load can skip serialization.
`ifdef XM_STORE_FWD_EN
  assign fwd_hit = (state == IDLE) && mem_top && we_top && mem_bot && !we_bot &&
                   (addr_top == addr_bot);
`else
  assign fwd_hit = 1'b0;
`endif

  // State register and capture of the deferred bottom access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bot_addr_q <= '0;
      bot_data_q <= '0;
      bot_we_q   <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
      if (state == IDLE && state_nxt == BOT) begin
        bot_addr_q <= addr_bot;
        bot_data_q <= data_bot;
        bot_we_q   <= we_bot;
      end
      if (fwd_hit) fwd_data_q <= data_top;
    end
  end

  // Next state: a dual access without forwarding spends one cycle in BOT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_top && mem_bot && !fwd_hit) state_nxt = BOT;
      BOT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: select which access drives dmem and what tag it leaves behind.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // can leave a value unassigned and infer a latch.
    dmem_address = '0;
    dmem_data    = '0;
    dmem_wren    = 1'b0;
    stall        = 1'b0;
    issue_tag    = TAG_NONE;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (mem_top) begin
            dmem_address = addr_top;
            dmem_data    = data_top;
            dmem_wren    = we_top;
            stall        = mem_bot && !fwd_hit;
            if (fwd_hit)
              issue_tag = '{issued: 1'b1, slot: 1'b1, is_load: 1'b1, fwd: 1'b1};
            else
              issue_tag = '{issued: 1'b1, slot: 1'b0, is_load: !we_top, fwd: 1'b0};
          end else if (mem_bot) begin
            dmem_address = addr_bot;
            dmem_data    = data_bot;
            dmem_wren    = we_bot;
            issue_tag    = '{issued: 1'b1, slot: 1'b1, is_load: !we_bot, fwd: 1'b0};
          end
        end
        BOT: begin
          dmem_address = bot_addr_q;
          dmem_data    = bot_data_q;
          dmem_wren    = bot_we_q;
          issue_tag    = '{issued: 1'b1, slot: 1'b1, is_load: !bot_we_q, fwd: 1'b0};
        end
        default: ;
      endcase
    end
  end

  // Tag pipeline and load-result capture; reset drops anything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_q0    <= TAG_NONE;
      tag_q1    <= TAG_NONE;
      rdata_top <= '0;
      rdata_bot <= '0;
    end else begin
      tag_q0 <= issue_tag;
      tag_q1 <= tag_q0;
      if (tag_q0.issued && tag_q0.is_load) begin
        if (!tag_q0.slot) rdata_top <= dmem_q;
        else              rdata_bot <= tag_q0.fwd ? fwd_data_q : dmem_q;
      end
    end
  end

  assign rvalid_top = tag_q1.issued && tag_q1.is_load && !tag_q1.slot;
  assign rvalid_bot = tag_q1.issued && tag_q1.is_load &&  tag_q1.slot;

endmodule

// File: tb/tb_xm_mem_port.sv
// tb_xm_mem_port: randomized + directed bench for xm_mem_port. A behavioural
// model tracks program-order memory contents and the cycle each load result
// is due, and compares every DUT output every cycle.
module tb_xm_mem_port;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int NSCHED = 8192;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              mem_top = 1'b0, mem_bot = 1'b0, we_top = 1'b0, we_bot = 1'b0;
  logic [ADDR_W-1:0] addr_top = '0, addr_bot = '0;
  logic [DATA_W-1:0] data_top = '0, data_bot = '0;
  logic [DATA_W-1:0] dmem_q;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_data;
  logic              dmem_wren, stall, rvalid_top, rvalid_bot;
  logic [DATA_W-1:0] rdata_top, rdata_bot;

  xm_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .mem_top(mem_top), .mem_bot(mem_bot), .we_top(we_top), .we_bot(we_bot),
    .addr_top(addr_top), .addr_bot(addr_bot), .data_top(data_top), .data_bot(data_bot),
    .dmem_q(dmem_q), .dmem_address(dmem_address), .dmem_data(dmem_data),
    .dmem_wren(dmem_wren), .stall(stall), .rdata_top(rdata_top), .rdata_bot(rdata_bot),
    .rvalid_top(rvalid_top), .rvalid_bot(rvalid_bot)
  );

  always #5 clock = ~clock;

  // Initial memory image shared by the memory and the model.
  function automatic logic [DATA_W-1:0] init_val(input int a);
    case (a)
      'h004: init_val = 32'h11111111;
      'h008: init_val = 32'h22222222;
      'h00C: init_val = 32'h33333333;
      'h010: init_val = 32'hDEADBEEF;
      default: init_val = 32'h5A000000 ^ (a * 32'h9E3779B1);
    endcase
  endfunction

  // Single-port synchronous data memory: registered read, write on wren.
  logic              preload = 1'b1;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= init_val(i);
      dmem_q <= '0;
    end else begin
      dmem_q <= mem[dmem_address];
      if (dmem_wren) mem[dmem_address] <= dmem_data;
    end
  end

  // ---------------- reference model ----------------
  int                n_checks = 0;
  int                n_pass = 0;
  int                cyc = 0;
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  bit                sv_top [0:NSCHED-1];
  bit                sv_bot [0:NSCHED-1];
  logic [DATA_W-1:0] sd_top [0:NSCHED-1];
  logic [DATA_W-1:0] sd_bot [0:NSCHED-1];
  logic [DATA_W-1:0] hold_top = '0, hold_bot = '0;
  bit                pend = 0;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic              p_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  logic              e_wren, e_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  task automatic sched(input bit slot, input int at, input logic [DATA_W-1:0] d);
    if (!slot) begin sv_top[at] = 1; sd_top[at] = d; end
    else       begin sv_bot[at] = 1; sd_bot[at] = d; end
  endtask

  // One access reaching memory this cycle, in program order.
  task automatic access(input bit slot, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic we);
    e_addr = a; e_data = d; e_wren = we;
    if (we) shadow[a] = d;
    else    sched(slot, cyc + 2, shadow[a]);
  endtask

  task automatic check_outputs();
    if (sv_top[cyc]) hold_top = sd_top[cyc];
    if (sv_bot[cyc]) hold_bot = sd_bot[cyc];
    check("stall",      stall,        e_stall);
    check("dmem_addr",  dmem_address, e_addr);
    check("dmem_data",  dmem_data,    e_data);
    check("dmem_wren",  dmem_wren,    e_wren);
    check("rvalid_top", rvalid_top,   sv_top[cyc]);
    check("rvalid_bot", rvalid_bot,   sv_bot[cyc]);
    check("rdata_top",  rdata_top,    hold_top);
    check("rdata_bot",  rdata_bot,    hold_bot);
    cyc++;
  endtask

  task automatic step(input logic mt, input logic wt, input logic [ADDR_W-1:0] at,
                      input logic [DATA_W-1:0] dt, input logic mb, input logic wb,
                      input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
    bit fwd;
    @(negedge clock);
    reset = 1'b0;
    mem_top = mt; we_top = wt; addr_top = at; data_top = dt;
    mem_bot = mb; we_bot = wb; addr_bot = ab; data_bot = db;
    #1;
    e_addr = '0; e_data = '0; e_wren = 1'b0; e_stall = 1'b0;
    if (pend) begin
      access(1'b1, p_addr, p_data, p_we);
      pend = 0;
    end else if (mt && mb) begin
      fwd = 0;
`ifdef XM_STORE_FWD_EN
      fwd = wt && !wb && (at == ab);
`endif
      access(1'b0, at, dt, wt);
      if (fwd) sched(1'b1, cyc + 2, dt);
      else begin
        pend = 1; p_addr = ab; p_data = db; p_we = wb; e_stall = 1'b1;
      end
    end else if (mt) access(1'b0, at, dt, wt);
    else if (mb)     access(1'b1, ab, db, wb);
    check_outputs();
  endtask

  task automatic reset_step();
    @(negedge clock);
    reset = 1'b1;
    mem_top = 0; mem_bot = 0; we_top = 0; we_bot = 0;
    addr_top = '0; addr_bot = '0; data_top = '0; data_bot = '0;
    #1;
    pend = 0; hold_top = '0; hold_bot = '0;
    for (int i = cyc; i < NSCHED; i++) begin sv_top[i] = 0; sv_bot[i] = 0; end
    e_addr = '0; e_data = '0; e_wren = 1'b0; e_stall = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] ra, rb;
    for (int i = 0; i < (1 << ADDR_W); i++) shadow[i] = init_val(i);
    for (int i = 0; i < NSCHED; i++) begin sv_top[i] = 0; sv_bot[i] = 0; end
    reset_step();
    reset_step();
    preload = 1'b0;

    // Reset in the middle of BOT after a dual load drops everything.
    step(1, 0, 12'h004, '0, 1, 0, 12'h008, '0);
    reset_step();
    idle(4);

    // Single top load.
    step(1, 0, 12'h010, '0, 0, 0, '0, '0);
    idle(3);
    check("single_rdata_top", rdata_top, 32'hDEADBEEF);

    // Dual load, pipeline frozen so inputs are held during BOT.
    step(1, 0, 12'h004, '0, 1, 0, 12'h008, '0);
    step(1, 0, 12'h004, '0, 1, 0, 12'h008, '0);
    idle(3);
    check("dual_rdata_top", rdata_top, 32'h11111111);
    check("dual_rdata_bot", rdata_bot, 32'h22222222);

    // Dual store to the same address: bottom wins.
    step(1, 1, 12'h020, 32'hA, 1, 1, 12'h020, 32'hB);
    step(1, 1, 12'h020, 32'hA, 1, 1, 12'h020, 32'hB);
    idle(2);
    check("dual_store_mem", mem[12'h020], 32'hB);

    // Top store then bottom load of the same address.
    step(1, 1, 12'h030, 32'h12345678, 1, 0, 12'h030, '0);
    idle(4);
    check("st_ld_rdata_bot", rdata_bot, 32'h12345678);

    // Dual load followed immediately by a single bottom load.
    step(1, 0, 12'h004, '0, 1, 0, 12'h008, '0);
    step(1, 0, 12'h004, '0, 1, 0, 12'h008, '0);
    step(0, 0, '0, '0, 1, 0, 12'h00C, '0);
    idle(3);
    check("b2b_rdata_bot", rdata_bot, 32'h33333333);

    // Randomized traffic over a small address window to provoke conflicts.
    for (int i = 0; i < 600; i++) begin
      ra = 12'h040 + 12'($urandom_range(0, 7));
      rb = ($urandom_range(0, 2) == 0) ? ra : 12'h040 + 12'($urandom_range(0, 7));
      step(1'($urandom), 1'($urandom), ra, $urandom,
           1'($urandom), 1'($urandom), rb, $urandom);
      if ($urandom_range(0, 60) == 0) reset_step();
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xm_mem_port.md
# xm_mem_port

Memory-stage port controller for the dual-issue pipeline. Takes the per-slot memory decode (`mem_*`, `we_*`) plus address/data of the top and bottom instructions in the X/M stage and drives the single-port data memory. When both slots need memory it serializes them top-then-bottom, stalling the front of the pipeline for one cycle, and returns load data to each slot with a valid pulse for writeback.

## Interface
Parameters:
- `ADDR_W`, 12, data memory word-address width
- `DATA_W`, 32, data word width

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `mem_top`, `mem_bot`  in  1  slot performs a memory access (load or store)
- `we_top`, `we_bot`  in  1  slot access is a store; ignored when the matching `mem_*` is 0
- `addr_top`, `addr_bot`  in  ADDR_W  per-slot memory address
- `data_top`, `data_bot`  in  DATA_W  per-slot store data
- `dmem_q`  in  DATA_W  data memory read data, valid one cycle after address
- `dmem_address`  out  ADDR_W  data memory address
- `dmem_data`  out  DATA_W  data memory write data
- `dmem_wren`  out  1  data memory write enable
- `stall`  out  1  freeze PC, F/D, D/X and X/M registers this cycle
- `rdata_top`, `rdata_bot`  out  DATA_W  held load result per slot
- `rvalid_top`, `rvalid_bot`  out  1  one-cycle pulse: matching `rdata_*` updated this cycle

## Operation
- FSM states: `IDLE`, `BOT`.
- `IDLE`, neither `mem_*`: dmem outputs driven 0, `stall`=0.
- `IDLE`, exactly one `mem_*`: that slot's addr/data/`we` driven to dmem combinationally, `stall`=0, remain `IDLE`.
- `IDLE`, both `mem_*`: top slot drives dmem, `stall`=1, latch bottom addr/data/`we`, next state `BOT`.
- `BOT`: latched bottom access drives dmem, `stall`=0, next state `IDLE`. Live slot inputs are ignored in `BOT`.
- Loads: a 2-entry tag pipeline records {issued, slot, is_load} per cycle; on the cycle `dmem_q` is valid for a load, `dmem_q` is registered into the matching `rdata_*` and the matching `rvalid_*` pulses the following cycle.
- Stores produce no `rvalid_*`. `rdata_*` hold their value until overwritten.
- Program order is preserved: top store followed by bottom load of the same address returns the stored value (serialization, or forwarding if configured). Both stores to the same address: bottom's data is final.

## Timing
- Reset: state `IDLE`; `stall`, `dmem_wren`, `rvalid_*` = 0; `dmem_address`, `dmem_data`, `rdata_*`, latches and tags = 0. Reset mid-`BOT` drops the pending bottom access; in-flight tags are cleared, so no `rvalid_*` fires.
- Single load issued cycle N: `dmem_q` valid N+1, `rdata_*`/`rvalid_*` in N+2.
- Dual load issued cycle N: top access N, bottom access N+1; `rvalid_top` in N+2, `rvalid_bot` in N+3; `stall` high only in N.
- Back-to-back accesses are accepted every cycle outside `stall`; tag pipeline keeps results per slot with no loss.
- `stall` is combinational from `mem_*` and state. It never asserts in `BOT` or for single-slot accesses.

## Configuration
- `XM_STORE_FWD_EN` defined: in `IDLE`, if `mem_top & we_top & mem_bot & ~we_bot` and `addr_top == addr_bot`, only the top store is issued. `stall`=0, no `BOT` state. `rdata_bot` gets `data_top` with `rvalid_bot` in N+2, the same cycle a normal load would report.
- Undefined: that case serializes like any other dual access (`stall` for 1 cycle, bottom load reads the stored value from memory).

## Test plan
- Reset asserted mid-`BOT` after dual load issue -> `stall`=0, `dmem_wren`=0, no `rvalid_*` afterwards, `rdata_*`=0.
- Single top load, addr 0x010, memory holds 0xDEADBEEF -> `stall` never 1, `rvalid_top` pulses 2 cycles later with `rdata_top`=0xDEADBEEF, `rvalid_bot` stays 0.
- Dual load, addr_top 0x004 (0x11111111), addr_bot 0x008 (0x22222222) -> `stall`=1 for exactly 1 cycle, `dmem_address` 0x004 then 0x008, `rvalid_top` at N+2 with 0x11111111, `rvalid_bot` at N+3 with 0x22222222.
- Dual store, both to addr 0x020, data_top 0xA, data_bot 0xB -> two writes in order, final memory[0x020]=0xB, no `rvalid_*`.
- Top store 0x12345678 to 0x030, bottom load 0x030 -> `rdata_bot`=0x12345678. With `XM_STORE_FWD_EN`: `stall` stays 0 and there is one dmem access. Without it: `stall`=1 for 1 cycle and there are two accesses.
- Dual load immediately followed by single bottom load (addr 0x00C, 0x33333333) -> three dmem accesses in consecutive cycles, all three `rvalid_*` pulses in order with correct data.
